// File: rtl/eth_chk_pkg.sv
// Shared types, constants and helpers for the Ethernet frame checker.
package eth_chk_pkg;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } state_t;

  localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned DEF_MIN_WORDS = 8;
  localparam int unsigned DEF_MAX_WORDS = 190;

  // Word counts live in 8 bits and stick at 255 so very long frames stay errored.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

  function automatic logic len_ok(input logic [7:0] len,
                                  input int unsigned min_w,
                                  input int unsigned max_w);
    return (32'(len) >= min_w) && (32'(len) <= max_w);
  endfunction

endpackage

// File: rtl/eth_sat_cnt.sv
// Saturating statistics counter; it can step by up to 3 in one cycle.
module eth_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+1:0] sum;

  always_comb begin
    sum   = {2'b00, cnt_q} + {{W{1'b0}}, inc};
    cnt_d = (sum > {2'b00, {W{1'b1}}}) ? {W{1'b1}} : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/eth_frame_chk.sv
// Ethernet frame checker: forwards framed words with one cycle of latency,
// checks frame length and keeps good/errored frame statistics.
module eth_frame_chk
  import eth_chk_pkg::*;
#(
  parameter int unsigned MIN_WORDS = DEF_MIN_WORDS,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      inData,
  input  logic             inSop,
  input  logic             inEop,
  input  logic             vld,
  output logic [63:0]      outData,
  output logic             outSop,
  output logic             outEop,
  output logic             outvld,
  output logic [47:0]      dstAddr,
  output logic             bcast,
  output logic [CNT_W-1:0] frameCnt,
  output logic [CNT_W-1:0] errCnt,
  output logic [7:0]       lastLen,
  output logic             errPulse
);

  state_t      state_q, state_d;
  logic [7:0]  word_cnt_q, word_cnt_d, next_cnt;
  logic [63:0] out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d, out_eop_q, out_eop_d, out_vld_q, out_vld_d;
  logic [47:0] dst_addr_q, dst_addr_d;
  logic        bcast_q, bcast_d, err_pulse_q, err_pulse_d;
  logic [7:0]  last_len_q, last_len_d;
  logic [1:0]  good_inc, err_inc;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    next_cnt    = sat_inc8(word_cnt_q);
    out_data_d  = out_data_q;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_vld_d   = 1'b0;
    dst_addr_d  = dst_addr_q;
    last_len_d  = last_len_q;
    good_inc    = 2'd0;
    err_inc     = 2'd0;

    if (state_q == IN_FRAME) begin
      // A gap or a fresh SOP ends the open frame as an error at its current length.
      if (!vld || inSop) begin
        err_inc    = 2'd1;
        last_len_d = word_cnt_q;
        state_d    = IDLE;
        word_cnt_d = 8'd0;
      end else begin
        out_vld_d  = 1'b1;
        out_data_d = inData;
        out_eop_d  = inEop;
        if (inEop) begin
          last_len_d = next_cnt;
          if (len_ok(next_cnt, MIN_WORDS, MAX_WORDS)) good_inc = 2'd1;
          else                                        err_inc  = 2'd1;
          state_d    = IDLE;
          word_cnt_d = 8'd0;
        end else begin
          word_cnt_d = next_cnt;
        end
      end
    end

    // An SOP always opens a frame, even right after aborting the previous one.
    if (vld && inSop) begin
      out_vld_d  = 1'b1;
      out_data_d = inData;
      out_sop_d  = 1'b1;
      out_eop_d  = inEop;
      dst_addr_d = inData[63:16];
      if (inEop) begin
        last_len_d = 8'd1;
        if (len_ok(8'd1, MIN_WORDS, MAX_WORDS)) good_inc = good_inc + 2'd1;
        else                                    err_inc  = err_inc + 2'd1;
        state_d    = IDLE;
        word_cnt_d = 8'd0;
      end else begin
        state_d    = IN_FRAME;
        word_cnt_d = 8'd1;
      end
    end

    err_pulse_d = (err_inc != 2'd0);
    bcast_d     = (dst_addr_d == BCAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_cnt_q  <= 8'd0;
      out_data_q  <= 64'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      dst_addr_q  <= 48'd0;
      bcast_q     <= 1'b0;
      last_len_q  <= 8'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_vld_q   <= out_vld_d;
      dst_addr_q  <= dst_addr_d;
      bcast_q     <= bcast_d;
      last_len_q  <= last_len_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  eth_sat_cnt #(.W(CNT_W)) u_frame_cnt (
    .clk (clk),
    .clr (reset),
    .inc (good_inc),
    .cnt (frameCnt)
  );

  eth_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .clr (reset),
    .inc (err_inc),
    .cnt (errCnt)
  );

  assign outData  = out_data_q;
  assign outSop   = out_sop_q;
  assign outEop   = out_eop_q;
  assign outvld   = out_vld_q;
  assign dstAddr  = dst_addr_q;
  assign bcast    = bcast_q;
  assign lastLen  = last_len_q;
  assign errPulse = err_pulse_q;

endmodule

// File: tb/tb_eth_frame_chk.sv
// Self-checking bench for eth_frame_chk, including a narrow-counter instance.
module tb_eth_frame_chk;

  localparam int MINW = 8;
  localparam int MAXW = 190;
  localparam int CW   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] inData;
  logic        inSop, inEop, vld;

  logic [63:0] outData;
  logic        outSop, outEop, outvld, bcast, errPulse;
  logic [47:0] dstAddr;
  logic [CW-1:0] frameCnt, errCnt;
  logic [7:0]  lastLen;

  logic [63:0] s_outData;
  logic        s_outSop, s_outEop, s_outvld, s_bcast, s_errPulse;
  logic [47:0] s_dstAddr;
  logic [1:0]  s_frameCnt, s_errCnt;
  logic [7:0]  s_lastLen;

  eth_frame_chk #(.MIN_WORDS(MINW), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .inData(inData), .inSop(inSop), .inEop(inEop), .vld(vld),
    .outData(outData), .outSop(outSop), .outEop(outEop), .outvld(outvld),
    .dstAddr(dstAddr), .bcast(bcast), .frameCnt(frameCnt), .errCnt(errCnt),
    .lastLen(lastLen), .errPulse(errPulse)
  );

  eth_frame_chk #(.MIN_WORDS(MINW), .MAX_WORDS(MAXW), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .inData(inData), .inSop(inSop), .inEop(inEop), .vld(vld),
    .outData(s_outData), .outSop(s_outSop), .outEop(s_outEop), .outvld(s_outvld),
    .dstAddr(s_dstAddr), .bcast(s_bcast), .frameCnt(s_frameCnt), .errCnt(s_errCnt),
    .lastLen(s_lastLen), .errPulse(s_errPulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_frame = 0, exp_err = 0, exp_last = 0, exp_pulses = 0, pulses = 0;
  logic [47:0] exp_dst = 48'd0;

  // exp_fwd says whether the word currently driven should be forwarded.
  logic        exp_fwd = 1'b0;
  logic        pipe_fwd, pipe_sop, pipe_eop;
  logic [63:0] pipe_data;
  logic [CW-1:0] prev_err = '0;

  always @(posedge clk) begin
    if (reset) begin
      pipe_fwd  <= 1'b0;
      pipe_sop  <= 1'b0;
      pipe_eop  <= 1'b0;
      pipe_data <= 64'd0;
    end else begin
      pipe_fwd <= exp_fwd;
      pipe_sop <= inSop;
      pipe_eop <= inEop;
      if (exp_fwd) pipe_data <= inData;
    end
  end

  // Word-stream scoreboard plus errPulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (outvld !== pipe_fwd) begin
        errors++;
        $display("[TB] FAIL outvld: got %b expected %b at %0t", outvld, pipe_fwd, $time);
      end
      checks++;
      if (outData !== pipe_data) begin
        errors++;
        $display("[TB] FAIL outData: got %h expected %h at %0t", outData, pipe_data, $time);
      end
      if (pipe_fwd) begin
        checks++;
        if (outSop !== pipe_sop || outEop !== pipe_eop) begin
          errors++;
          $display("[TB] FAIL sop_eop: got %b%b expected %b%b at %0t",
                   outSop, outEop, pipe_sop, pipe_eop, $time);
        end
      end
      if (errPulse === 1'b1) begin
        pulses++;
        checks++;
        if (errCnt === prev_err) begin
          errors++;
          $display("[TB] FAIL pulse_cnt_sync: errCnt %0d unchanged with errPulse at %0t",
                   errCnt, $time);
        end
      end
    end
    prev_err = errCnt;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic [63:0] d, input logic s, input logic e,
                       input logic v, input logic f);
    inData  = d;
    inSop   = s;
    inEop   = e;
    vld     = v;
    exp_fwd = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic note_term(input int len, input bit eop_seen);
    int l;
    l = (len > 255) ? 255 : len;
    exp_last = l;
    if (eop_seen && l >= MINW && l <= MAXW) exp_frame++;
    else begin
      exp_err++;
      exp_pulses++;
    end
  endtask

  task automatic send_words(input int len, input logic [47:0] dst, input bit with_eop);
    logic [63:0] d;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[63:16] = dst;
      drive(d, i == 0, with_eop && (i == len - 1), 1'b1, 1'b1);
    end
    exp_dst = dst;
  endtask

  // kind 0 ends with EOP, kind 1 is truncated by a vld gap.
  task automatic send_frame(input int len, input logic [47:0] dst, input int kind);
    send_words(len, dst, kind == 0);
    if (kind == 1) idle(1);
    note_term(len, kind == 0);
  endtask

  task automatic check_stats(input string name);
    int sf, se;
    idle(2);
    sf = (exp_frame > 3) ? 3 : exp_frame;
    se = (exp_err > 3) ? 3 : exp_err;
    checks++;
    if (frameCnt !== CW'(exp_frame)) begin
      errors++; $display("[TB] FAIL %s frameCnt: got %0d expected %0d", name, frameCnt, exp_frame);
    end
    checks++;
    if (errCnt !== CW'(exp_err)) begin
      errors++; $display("[TB] FAIL %s errCnt: got %0d expected %0d", name, errCnt, exp_err);
    end
    checks++;
    if (lastLen !== 8'(exp_last)) begin
      errors++; $display("[TB] FAIL %s lastLen: got %0d expected %0d", name, lastLen, exp_last);
    end
    checks++;
    if (pulses !== exp_pulses) begin
      errors++; $display("[TB] FAIL %s errPulse count: got %0d expected %0d", name, pulses, exp_pulses);
    end
    checks++;
    if (dstAddr !== exp_dst || bcast !== (exp_dst == 48'hFFFF_FFFF_FFFF)) begin
      errors++; $display("[TB] FAIL %s dst/bcast: got %h/%b expected %h/%b", name, dstAddr, bcast,
                         exp_dst, exp_dst == 48'hFFFF_FFFF_FFFF);
    end
    checks++;
    if (s_frameCnt !== 2'(sf) || s_errCnt !== 2'(se)) begin
      errors++; $display("[TB] FAIL %s narrow counters: got %0d/%0d expected %0d/%0d", name,
                         s_frameCnt, s_errCnt, sf, se);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (outData !== 64'd0 || outSop !== 1'b0 || outEop !== 1'b0 || outvld !== 1'b0) begin
      errors++; $display("[TB] FAIL %s stream: got %h %b%b%b expected all zero", name,
                         outData, outSop, outEop, outvld);
    end
    checks++;
    if (dstAddr !== 48'd0 || bcast !== 1'b0 || lastLen !== 8'd0 || errPulse !== 1'b0) begin
      errors++; $display("[TB] FAIL %s status: got %h %b %0d %b expected all zero", name,
                         dstAddr, bcast, lastLen, errPulse);
    end
    checks++;
    if (frameCnt !== '0 || errCnt !== '0) begin
      errors++; $display("[TB] FAIL %s counters: got %0d/%0d expected 0/0", name, frameCnt, errCnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame();
    send_frame(10, 48'h0011_2233_4455, 0);
    check_stats("good_frame");
  endtask

  task automatic test_runt_bcast();
    send_frame(1, 48'hFFFF_FFFF_FFFF, 0);
    check_stats("runt_bcast");
  endtask

  task automatic test_long_frame();
    send_frame(200, 48'h0A0B_0C0D_0E0F, 0);
    check_stats("long_frame");
  endtask

  task automatic test_abort();
    logic [63:0] d;
    send_words(5, 48'h1234_5678_9ABC, 1'b0);
    d = {$urandom, $urandom};
    d[63:16] = 48'h0000_0000_0042;
    drive(d, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_err++; exp_pulses++; exp_last = 5;
    checks++;
    if (lastLen !== 8'd5 || errCnt !== CW'(exp_err) || errPulse !== 1'b1) begin
      errors++; $display("[TB] FAIL abort: got lastLen %0d errCnt %0d errPulse %b expected 5 %0d 1",
                         lastLen, errCnt, errPulse, exp_err);
    end
    for (int i = 1; i < 9; i++) drive({$urandom, $urandom}, 1'b0, i == 8, 1'b1, 1'b1);
    exp_dst = 48'h0000_0000_0042;
    note_term(9, 1'b1);
    check_stats("abort_restart");
  endtask

  task automatic test_stray_trunc();
    for (int i = 0; i < 3; i++) drive({$urandom, $urandom}, 1'b0, i == 2, 1'b1, 1'b0);
    send_frame(6, 48'h00AA_BBCC_DDEE, 1);
    check_stats("stray_trunc");
  endtask

  task automatic test_back_to_back();
    send_frame(8, 48'h0102_0304_0506, 0);
    send_frame(190, 48'h0607_0809_0A0B, 0);
    send_frame(191, 48'h1111_2222_3333, 0);
    check_stats("back_to_back");
  endtask

  task automatic test_reset_mid();
    send_words(4, 48'h0F0E_0D0C_0B0A, 1'b0);
    reset = 1'b1;
    idle(2);
    check_reset_outputs("reset_mid");
    reset = 1'b0;
    exp_frame = 0; exp_err = 0; exp_last = 0; exp_pulses = 0; pulses = 0; exp_dst = 48'd0;
    idle(1);
    send_frame(8, 48'h2468_ACE0_1357, 0);
    check_stats("after_reset");
  endtask

  task automatic test_random();
    int len, kind;
    logic [63:0] r;
    logic [47:0] dst;
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 9))
        0: len = 1;
        1: len = 7;
        2: len = 8;
        3: len = 9;
        4: len = 190;
        5: len = 191;
        6: len = 260;
        default: len = $urandom_range(10, 189);
      endcase
      kind = $urandom_range(0, 1);
      r = {$urandom, $urandom};
      dst = ($urandom_range(0, 4) == 0) ? 48'hFFFF_FFFF_FFFF : r[47:0];
      if ($urandom_range(0, 3) == 0)
        for (int s = 0; s < 2; s++) drive({$urandom, $urandom}, 1'b0, s[0], 1'b1, 1'b0);
      send_frame(len, dst, kind);
      check_stats("random");
    end
  endtask

  initial begin
    reset  = 1'b1;
    inData = 64'd0;
    inSop  = 1'b0;
    inEop  = 1'b0;
    vld    = 1'b0;
    test_reset();
    test_good_frame();
    test_runt_bcast();
    test_long_frame();
    test_abort();
    test_stray_trunc();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
